hilo_muldiv_unit: RTL

HILO_MULDIV_UNIT -- requirements
Module: hilo_muldiv_unit

---
 rtl/hilo_muldiv_unit.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply-divide unit: iterative shift-add multiply (with accumulate) and restoring divide.
// The divider is only built when the HILO_DIV_EN macro is defined.
module hilo_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [3:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic             DivByZero,
   output logic [WIDTH-1:0] ReadHi,
   output logic [WIDTH-1:0] ReadLo
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [3:0] OP_MULT  = 4'd0;
   localparam logic [3:0] OP_MULTU = 4'd1;
   localparam logic [3:0] OP_MADD  = 4'd2;
   localparam logic [3:0] OP_MADDU = 4'd3;
   localparam logic [3:0] OP_MSUB  = 4'd4;
   localparam logic [3:0] OP_MSUBU = 4'd5;
   localparam logic [3:0] OP_DIV   = 4'd6;
   localparam logic [3:0] OP_DIVU  = 4'd7;
   localparam logic [3:0] OP_MTHI  = 4'd8;
   localparam logic [3:0] OP_MTLO  = 4'd9;

`ifdef HILO_DIV_EN
   typedef enum logic [1:0] {IDLE, MUL, DIV, COMMIT} state_t;
`else
   typedef enum logic [1:0] {IDLE, MUL, COMMIT} state_t;
`endif

   state_t                 state_reg;
   logic [3:0]             op_reg;
   logic [WIDTH-1:0]       hi_reg;
   logic [WIDTH-1:0]       lo_reg;
   logic                   busy_reg;
   logic                   done_reg;
   logic [CW-1:0]          cnt_reg;
   // Shared work register: {partial product, multiplier} or {remainder, quotient}
   logic [2*WIDTH-1:0]     prod_reg;
   logic [WIDTH-1:0]       mcand_reg;
   logic                   neg_reg;

   logic                   legal;
   logic                   signed_op;
   logic                   skip_write;
   logic [WIDTH:0]         mul_sum;
   logic [2*WIDTH-1:0]     mul_next;
   logic [2*WIDTH-1:0]     prod_signed;
   logic [2*WIDTH-1:0]     commit_hilo;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
      return (sgn && x[WIDTH-1]) ? -x : x;
   endfunction

   assign signed_op = ~Op[0];

   always_comb begin
      legal = 1'b0;
      case (Op)
         OP_MULT, OP_MULTU, OP_MADD, OP_MADDU,
         OP_MSUB, OP_MSUBU, OP_MTHI, OP_MTLO: legal = 1'b1;
`ifdef HILO_DIV_EN
         OP_DIV, OP_DIVU:                     legal = 1'b1;
`endif
         default:                             legal = 1'b0;
      endcase
   end

   assign mul_sum     = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + (prod_reg[0] ? {1'b0, mcand_reg} : '0);
   assign mul_next    = {mul_sum, prod_reg[WIDTH-1:1]};
   assign prod_signed = neg_reg ? -prod_reg : prod_reg;

`ifdef HILO_DIV_EN
   logic                   dbz_reg;
   logic                   dz_pend_reg;
   logic                   rneg_reg;
   logic [WIDTH:0]         div_shift;
   logic [WIDTH:0]         div_diff;
   logic [2*WIDTH-1:0]     div_next;

   // Restoring step: shift in the next dividend bit, keep the subtraction only if it did not borrow
   assign div_shift  = prod_reg[2*WIDTH-1:WIDTH-1];
   assign div_diff   = div_shift - {1'b0, mcand_reg};
   assign div_next   = {div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0],
                        prod_reg[WIDTH-2:0], ~div_diff[WIDTH]};
   assign skip_write = dz_pend_reg;
   assign DivByZero  = dbz_reg;
`else
   assign skip_write = 1'b0;
   assign DivByZero  = 1'b0;
`endif

   always_comb begin
      commit_hilo = prod_signed;
      case (op_reg)
         OP_MADD, OP_MADDU: commit_hilo = {hi_reg, lo_reg} + prod_signed;
         OP_MSUB, OP_MSUBU: commit_hilo = {hi_reg, lo_reg} - prod_signed;
`ifdef HILO_DIV_EN
         OP_DIV, OP_DIVU:
            commit_hilo = {rneg_reg ? -prod_reg[2*WIDTH-1:WIDTH] : prod_reg[2*WIDTH-1:WIDTH],
                           neg_reg  ? -prod_reg[WIDTH-1:0]       : prod_reg[WIDTH-1:0]};
`endif
         default: commit_hilo = prod_signed;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_reg <= IDLE;
         op_reg    <= '0;
         hi_reg    <= '0;
         lo_reg    <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         cnt_reg   <= '0;
         prod_reg  <= '0;
         mcand_reg <= '0;
         neg_reg   <= 1'b0;
`ifdef HILO_DIV_EN
         dbz_reg     <= 1'b0;
         dz_pend_reg <= 1'b0;
         rneg_reg    <= 1'b0;
`endif
      end else begin
         done_reg <= 1'b0;
`ifdef HILO_DIV_EN
         dbz_reg  <= 1'b0;
`endif
         case (state_reg)
            IDLE: begin
               if (Start && legal) begin
                  op_reg  <= Op;
                  cnt_reg <= '0;
                  neg_reg <= signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
`ifdef HILO_DIV_EN
                  rneg_reg    <= signed_op & A[WIDTH-1];
                  dz_pend_reg <= 1'b0;
`endif
                  if (Op == OP_MTHI) begin
                     hi_reg   <= A;
                     done_reg <= 1'b1;
                  end else if (Op == OP_MTLO) begin
                     lo_reg   <= A;
                     done_reg <= 1'b1;
`ifdef HILO_DIV_EN
                  end else if (Op == OP_DIV || Op == OP_DIVU) begin
                     busy_reg    <= 1'b1;
                     mcand_reg   <= mag(B, signed_op);
                     prod_reg    <= {{WIDTH{1'b0}}, mag(A, signed_op)};
                     dz_pend_reg <= (B == '0);
                     state_reg   <= (B == '0) ? COMMIT : DIV;
`endif
                  end else begin
                     busy_reg  <= 1'b1;
                     mcand_reg <= mag(A, signed_op);
                     prod_reg  <= {{WIDTH{1'b0}}, mag(B, signed_op)};
                     state_reg <= MUL;
                  end
               end
            end
            MUL: begin
               prod_reg <= mul_next;
               cnt_reg  <= cnt_reg + 1'b1;
               if (cnt_reg == CW'(WIDTH-1)) state_reg <= COMMIT;
            end
`ifdef HILO_DIV_EN
            DIV: begin
               prod_reg <= div_next;
               cnt_reg  <= cnt_reg + 1'b1;
               if (cnt_reg == CW'(WIDTH-1)) state_reg <= COMMIT;
            end
`endif
            COMMIT: begin
               if (!skip_write) {hi_reg, lo_reg} <= commit_hilo;
`ifdef HILO_DIV_EN
               dbz_reg <= dz_pend_reg;
`endif
               done_reg  <= 1'b1;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign Busy   = busy_reg;
   assign Done   = done_reg;
   assign ReadHi = hi_reg;
   assign ReadLo = lo_reg;

endmodule
